dut_stim_sequencer: RTL and testbench

- Synthesizable run controller that sequences a wide-input/wide-output DUT in place of a behavioural bench loop.
- Generates the DUT reset window and deterministic LCG stimulus, 32 bits per step, low word first.
- Counts applied cycles and compresses DUT outputs into a 32-bit MISR signature.
- Sits between a host/regression harness and the DUT's clk/rst_n/in_flat/out_flat boundary.

---
 rtl/stim_seq_pkg.sv | 10 +
 rtl/sig_misr.sv | 24 ++
 rtl/dut_stim_sequencer.sv | 109 ++++++++++
 tb/tb_dut_stim_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg: shared constants, LCG step and FSM state type for the stimulus sequencer
package stim_seq_pkg;
  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_e;
  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * LCG_MUL + LCG_INC;
  endfunction
endpackage

// File: rtl/sig_misr.sv
// sig_misr: folds a wide response into 32 bits and compacts it into a MISR signature
module sig_misr
  import stim_seq_pkg::*;
#(
  parameter int OUT_W = 159
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] data_i,
  output logic [31:0]      sig_o
);
  logic [31:0] fold, sig_d, sig_q;
  always_comb begin
    fold = '0;
    for (int i = 0; i < OUT_W; i++) fold[i[4:0]] = fold[i[4:0]] ^ data_i[i];
  end
  assign sig_d = clr_i ? '0 : en_i ? {sig_q[30:0], ^(sig_q & MISR_TAPS)} ^ fold : sig_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= '0;
    else sig_q <= sig_d;
  assign sig_o = sig_q;
endmodule

// File: rtl/dut_stim_sequencer.sv
// dut_stim_sequencer: drives DUT reset and LCG stimulus, counts vectors and signs the responses
module dut_stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int IN_W       = 135,
  parameter int OUT_W      = 159,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  in_flat,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_count,
  output logic [31:0]      signature
);
  localparam int RCW = $clog2(RST_CYCLES + 1);
  state_e           state_q;
  logic [31:0]      lcg_q, lcg_d;
  logic [IN_W-1:0]  vec, in_flat_q;
  logic [CNT_W-1:0] cycles_q, cnt_q;
  logic [RCW-1:0]   rcnt_q;
  logic             dut_rst_n_q, busy_q, done_q, take, last_rst, last_run;
  assign take     = state_q == IDLE && start;
  assign last_rst = rcnt_q == RCW'(RST_CYCLES - 1);
  assign last_run = cnt_q + CNT_W'(1) == cycles_q;
  // In IDLE the builder chains from seed so the first vector is ready on the start edge.
  always_comb begin
    lcg_d = state_q == IDLE ? seed : lcg_q;
    vec   = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (i[4:0] == 5'd0) lcg_d = lcg_step(lcg_d);
      vec[i] = lcg_d[i[4:0]];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      lcg_q       <= '0;
      in_flat_q   <= '0;
      cycles_q    <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      dut_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= RESET;
          lcg_q     <= lcg_d;
          in_flat_q <= vec;
          cycles_q  <= cycles;
          cnt_q     <= '0;
          rcnt_q    <= '0;
          busy_q    <= 1'b1;
        end
        RESET: if (abort) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (last_rst) begin
          state_q     <= cycles_q == '0 ? DONE : RUN;
          dut_rst_n_q <= cycles_q != '0;
          busy_q      <= cycles_q != '0;
          done_q      <= cycles_q == '0;
        end else rcnt_q <= rcnt_q + RCW'(1);
        RUN: if (abort) begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          dut_rst_n_q <= 1'b0;
        end else begin
          lcg_q     <= lcg_d;
          in_flat_q <= vec;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (last_run) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          dut_rst_n_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  sig_misr #(.OUT_W(OUT_W)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (take),
    .en_i  (state_q == RUN && !abort),
    .data_i(out_flat),
    .sig_o (signature)
  );
  assign dut_rst_n = dut_rst_n_q;
  assign in_flat   = in_flat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cyc_count = cnt_q;
endmodule

// File: tb/tb_dut_stim_sequencer.sv
// tb_dut_stim_sequencer: table-driven and randomized checks of the sequencer against a run-level model
module tb_dut_stim_sequencer;
  localparam int IN_W = 135, OUT_W = 159, RST_CYCLES = 2, CNT_W = 32;
  localparam int NW = (IN_W + 31) / 32, NCH = (OUT_W + 31) / 32;
  typedef struct {
    logic [31:0] seed;
    logic [31:0] cyc;
    int          mode;
    int          abort_at;
    logic [31:0] exp_sig;
    logic [31:0] exp_cnt;
    bit          has_exp;
  } rec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] seed = '0;
  logic [CNT_W-1:0] cycles = '0;
  logic dut_rst_n, busy, done;
  logic [IN_W-1:0] in_flat;
  logic [OUT_W-1:0] out_flat = '0;
  logic [CNT_W-1:0] cyc_count;
  logic [31:0] signature;
  int checks = 0, errors = 0;
  rec_t tbl[10];
  always #5 clk = ~clk;
  dut_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed), .cycles(cycles),
    .dut_rst_n(dut_rst_n), .in_flat(in_flat), .out_flat(out_flat), .busy(busy), .done(done),
    .cyc_count(cyc_count), .signature(signature)
  );
  task automatic chk(input string nm, input logic [199:0] a, input logic [199:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic next_vec(inout logic [31:0] s, output logic [IN_W-1:0] v);
    logic [NW*32-1:0] w;
    for (int k = 0; k < NW; k++) begin
      s = s * 32'h41C64E6D + 32'h3039;
      w[32*k +: 32] = s;
    end
    v = w[IN_W-1:0];
  endtask
  function automatic logic [31:0] misr(input logic [31:0] sg, input logic [OUT_W-1:0] o);
    logic [NCH*32-1:0] p;
    logic [31:0] f;
    p = '0;
    p[OUT_W-1:0] = o;
    f = '0;
    for (int k = 0; k < NCH; k++) f ^= p[32*k +: 32];
    return {sg[30:0], sg[31] ^ sg[21] ^ sg[1] ^ sg[0]} ^ f;
  endfunction
  function automatic logic [OUT_W-1:0] gen(input int mode);
    logic [OUT_W-1:0] w;
    for (int i = 0; i < OUT_W; i++) w[i] = 1'($urandom_range(0, 1));
    return mode == 0 ? '0 : mode == 1 ? OUT_W'(1) : w;
  endfunction
  task automatic expect_state(input string nm, input logic b, input logic r, input logic d,
                              input logic [IN_W-1:0] v, input int n, input logic [31:0] sg);
    chk({nm, "_busy"}, 200'(busy), 200'(b));
    chk({nm, "_dut_rst_n"}, 200'(dut_rst_n), 200'(r));
    chk({nm, "_done"}, 200'(done), 200'(d));
    chk({nm, "_in_flat"}, 200'(in_flat), 200'(v));
    chk({nm, "_cyc_count"}, 200'(cyc_count), 200'(n));
    chk({nm, "_signature"}, 200'(signature), 200'(sg));
  endtask
  task automatic run(input rec_t r);
    logic [31:0] s, msig;
    logic [IN_W-1:0] v;
    int n, nb;
    bit ab;
    s = r.seed; msig = '0; n = 0; nb = 0; ab = 1'b0;
    seed = r.seed; cycles = r.cyc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed = $urandom; cycles = $urandom;
    next_vec(s, v);
    if (r.seed == 32'd0) chk("seed0_low_words", 200'(in_flat[63:0]), 200'(64'hD3DC167E_00003039));
    for (int t = 0; t < RST_CYCLES; t++) begin
      out_flat = gen(r.mode);
      nb += int'(busy);
      expect_state("reset", 1'b1, 1'b0, 1'b0, v, 0, 32'd0);
      @(posedge clk); #1;
    end
    while (n < int'(r.cyc) && !ab) begin
      out_flat = gen(r.mode);
      abort = r.abort_at == n + 1;
      nb += int'(busy);
      expect_state("run", 1'b1, 1'b1, 1'b0, v, n, msig);
      @(posedge clk); #1;
      ab = abort; abort = 1'b0;
      if (!ab) begin
        msig = misr(msig, out_flat);
        next_vec(s, v);
        n++;
      end
    end
    if (!ab) begin
      nb += int'(busy);
      expect_state("done", 1'b0, r.cyc != 0, 1'b1, v, n, msig);
      @(posedge clk); #1;
    end
    expect_state("idle", 1'b0, 1'b0, 1'b0, v, n, msig);
    chk("busy_cycles", 200'(nb), 200'(RST_CYCLES + (ab ? r.abort_at : int'(r.cyc))));
    if (r.has_exp) begin
      chk("tbl_signature", 200'(signature), 200'(r.exp_sig));
      chk("tbl_cyc_count", 200'(cyc_count), 200'(r.exp_cnt));
    end
  endtask
  initial begin
    logic [31:0] s;
    logic [IN_W-1:0] v;
    tbl[0] = '{32'd0, 32'd1, 0, 0, 32'd0, 32'd1, 1'b1};
    tbl[1] = '{32'd468399889, 32'd100, 0, 0, 32'd0, 32'd100, 1'b1};
    tbl[2] = '{32'h1234_5678, 32'd0, 2, 0, 32'd0, 32'd0, 1'b1};
    tbl[3] = '{32'd7, 32'd1, 1, 0, 32'h1, 32'd1, 1'b1};
    tbl[4] = '{32'd7, 32'd2, 1, 0, 32'h2, 32'd2, 1'b1};
    tbl[5] = '{32'd99, 32'd10, 0, 5, 32'd0, 32'd4, 1'b1};
    for (int i = 6; i < 10; i++) begin
      tbl[i].seed = $urandom;
      tbl[i].cyc = $urandom_range(1, 30);
      tbl[i].mode = 2;
      tbl[i].abort_at = i[0] ? int'($urandom_range(1, tbl[i].cyc)) : 0;
      tbl[i].exp_sig = '0; tbl[i].exp_cnt = '0; tbl[i].has_exp = 1'b0;
    end
    #12;
    expect_state("por", 1'b0, 1'b0, 1'b0, '0, 0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; seed = 32'd1; cycles = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_beats_abort_busy", 200'(busy), 200'(1'b1));
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_reset_busy", 200'(busy), 200'(1'b0));
    chk("abort_reset_done", 200'(done), 200'(1'b0));
    @(posedge clk); #1;
    chk("abort_reset_no_done", 200'(done), 200'(1'b0));
    for (int i = 0; i < 10; i++) run(tbl[i]);
    seed = 32'd5; cycles = 32'd50; start = 1'b1; out_flat = '0;
    @(posedge clk); #1;
    start = 1'b0; s = 32'd5;
    next_vec(s, v);
    repeat (RST_CYCLES) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      start = i == 3; seed = 32'd0; cycles = 32'd1;
      chk("busy_run_in_flat", 200'(in_flat), 200'(v));
      chk("busy_run_count", 200'(cyc_count), 200'(i));
      @(posedge clk); #1;
      start = 1'b0;
      next_vec(s, v);
    end
    chk("start_ignored_busy", 200'(busy), 200'(1'b1));
    chk("start_ignored_in_flat", 200'(in_flat), 200'(v));
    #2 rst_n = 1'b0;
    #1 expect_state("async_rst", 1'b0, 1'b0, 1'b0, '0, 0, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
